dac12_tx: RTL
=============

DAC12_TX -- requirements
Module: dac12_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16: sample FIFO depth, power of two, 4..256.
REQ-002 SHALL have parameter PRIME_LEVEL, default 4: FIFO fill level required to leave PRIME, 1..DEPTH.
REQ-003 SHALL have port DAC_CLK  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port ENABLE  input  1: playback enable, level-sensitive.
REQ-006 SHALL have port RATE  input  8: output period minus one; one sample every RATE+1 clocks.
REQ-007 SHALL have port DIN  input  12: two's-complement sample.
REQ-008 SHALL have port DIN_VALID  input  1: DIN is valid.
REQ-009 SHALL have port DIN_READY  output  1: the FIFO is not full.
REQ-010 SHALL have port DAC_DATA  output  12: registered offset-binary DAC word.
REQ-011 SHALL have port DAC_WR  output  1: one-clock strobe, high in the cycle that DAC_DATA takes a new value.
REQ-012 SHALL have port UNDERRUN  output  1: sticky; FIFO was empty on a RUN tick.
REQ-013 SHALL have port LEVEL  output  $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-014 SHALL write DIN into the FIFO on every clock where DIN_VALID and DIN_READY are both high; LEVEL increments on the next clock.
REQ-015 SHALL keep DIN_READY = (LEVEL < DEPTH), independent of DIN_VALID and of state.
REQ-016 SHALL support a FIFO write and read in the same clock, with LEVEL unchanged, including at LEVEL = DEPTH and LEVEL = 0 (the write is accepted only if DIN_READY).
REQ-017 SHALL implement a rate counter that loads RATE and produces a one-clock tick when it reaches 0 and reloads; the counter runs only in RUN and is reloaded on entry to RUN.
REQ-018 SHALL have FSM states IDLE, PRIME and RUN.
REQ-019 SHALL go from IDLE to PRIME when ENABLE = 1.
REQ-020 SHALL go from PRIME to RUN when LEVEL >= PRIME_LEVEL.
REQ-021 SHALL go from any state to IDLE when ENABLE = 0; this takes priority over all other transitions.
REQ-022 SHALL, in IDLE, hold DAC_DATA = 12'h800 (midscale) and DAC_WR = 0; FIFO contents are retained.
REQ-023 SHALL, in PRIME, hold DAC_DATA at its last value with DAC_WR = 0.
REQ-024 SHALL, on a RUN tick with LEVEL > 0, pop one sample and on the next clock set DAC_DATA = sample XOR 12'h800, DAC_WR = 1.
REQ-025 SHALL have a latency from DIN accept (cycle t) to DAC_DATA/DAC_WR of at least 2 clocks (tick no earlier than t+1, output at t+2).
REQ-026 SHALL, on a RUN tick with LEVEL = 0, hold DAC_DATA, keep DAC_WR = 0, set UNDERRUN and stay in RUN; playback resumes on the next tick that finds data.
REQ-027 SHALL clear UNDERRUN only on reset or on the IDLE-to-PRIME transition.
REQ-028 SHALL, when RATE = 0, produce a tick every clock in RUN (DAC_WR may stay high continuously).
REQ-029 SHALL sample RATE changes at counter reload only; a changed RATE never truncates the current period.

Reset
REQ-030 SHALL, on RST = 1 at a clock edge, set the state to IDLE, empty the FIFO (LEVEL = 0), set DAC_DATA = 12'h800, DAC_WR = 0 and UNDERRUN = 0, and reload the rate counter.
REQ-031 SHALL give reset priority over ENABLE and DIN_VALID; a write in the reset cycle is dropped.
REQ-032 SHALL make reset mid-RUN take effect on the next edge, with no further DAC_WR.

Structure
REQ-033 SHALL place the MIDSCALE constant (12'h800), the sample width (12) and the state encoding in the shared package dac12_pkg.
REQ-034 SHALL implement the FIFO as a sub-module sync_fifo (parameterised width and depth, registered read, level output); the FSM, rate counter and output register live in dac12_tx.

Verification
REQ-035 SHALL include a bench scenario: reset, ENABLE=1, RATE=3, push 8'h... samples 12'h000, 12'h7FF, 12'h800, 12'hFFF -> RUN entered at LEVEL=4; DAC_DATA = 800, FFF, 000, 7FF, with DAC_WR every 4 clocks.
REQ-036 SHALL include a bench scenario: push 2 samples with RATE=1, then stop -> 2 strobes, then UNDERRUN=1 and DAC_DATA holding the last value; a new push resumes output with UNDERRUN still 1.
REQ-037 SHALL include a bench scenario: DIN_VALID held high with ENABLE=0 -> DIN_READY falls after DEPTH writes, LEVEL=DEPTH, DAC_DATA=800, no DAC_WR.
REQ-038 SHALL include a bench scenario: RATE=0 with a full FIFO and continuous push -> DAC_WR high every clock, LEVEL constant, and no sample lost or duplicated (scoreboard).
REQ-039 SHALL include a bench scenario: ENABLE dropped mid-RUN -> next clock IDLE with DAC_DATA=800; re-enable -> PRIME, UNDERRUN cleared, and remaining FIFO data played in order.
REQ-040 SHALL include a bench scenario: RST asserted mid-RUN while pushing -> next clock LEVEL=0, DAC_DATA=800, all flags 0.

Source files
------------

// File: rtl/dac12_pkg.sv
// Shared constants for the 12-bit DAC transmit path: sample width, midscale code
// and the playback state encoding.
package dac12_pkg;

    localparam int SAMPLE_W = 12;
    localparam int RATE_W   = 8;

    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
        return s ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered show-ahead read port and an occupancy count.
// rd_data always holds the head word, so a pop can hand it straight to a register.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic             push;
    logic             pop;

    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign push     = wr_en && !full;
    assign pop      = rd_en && !empty;
    assign rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            // Bypass when the word landing on this edge becomes the new head.
            rd_data <= (push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac12_tx.sv
// Paced DAC sample transmitter: buffers two's-complement samples and plays them out
// as offset-binary words, one every RATE+1 clocks.
//
// state | meaning
// IDLE  | output parked at midscale, no strobes, FIFO contents kept
// PRIME | filling the FIFO up to PRIME_LEVEL, output held
// RUN   | rate counter running, one pop per tick, underrun on an empty tick
module dac12_tx
    import dac12_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                   DAC_CLK,
    input  logic                   RST,
    input  logic                   ENABLE,
    input  logic [RATE_W-1:0]      RATE,
    input  logic [SAMPLE_W-1:0]    DIN,
    input  logic                   DIN_VALID,
    output logic                   DIN_READY,
    output logic [SAMPLE_W-1:0]    DAC_DATA,
    output logic                   DAC_WR,
    output logic                   UNDERRUN,
    output logic [$clog2(DEPTH):0] LEVEL
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

    logic [1:0]          state_q;
    logic [1:0]          state_n;
    logic [RATE_W-1:0]   rate_cnt_q;
    logic                running;
    logic                tick;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;

    sync_fifo #(
        .WIDTH(SAMPLE_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (DAC_CLK),
        .rst    (RST),
        .wr_en  (DIN_VALID),
        .wr_data(DIN),
        .rd_en  (pop),
        .rd_data(fifo_head),
        .level  (LEVEL),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign DIN_READY = !fifo_full;
    assign running   = (state_q == ST_RUN) && ENABLE;
    assign tick      = running && (rate_cnt_q == '0);
    assign pop       = tick && !fifo_empty;

    always_comb begin
        state_n = state_q;
        if (!ENABLE) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_n = ST_PRIME;
                ST_PRIME: if (LEVEL >= PRIME_L) state_n = ST_RUN;
                ST_RUN:   state_n = ST_RUN;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge DAC_CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rate_cnt_q <= RATE;
            DAC_DATA   <= MIDSCALE;
            DAC_WR     <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            state_q <= state_n;
            DAC_WR  <= pop;

            // Outside RUN the counter sits loaded, so RUN always starts a full period.
            if (!running || tick) begin
                rate_cnt_q <= RATE;
            end else begin
                rate_cnt_q <= rate_cnt_q - RATE_W'(1);
            end

            if (state_n == ST_IDLE) begin
                DAC_DATA <= MIDSCALE;
            end else if (pop) begin
                DAC_DATA <= to_offset_binary(fifo_head);
            end

            if (state_q == ST_IDLE && state_n == ST_PRIME) begin
                UNDERRUN <= 1'b0;
            end else if (tick && fifo_empty) begin
                UNDERRUN <= 1'b1;
            end
        end
    end

endmodule
